regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback front end for the single-write-port register file: per-source FIFOs
// feeding a round-robin arbiter that drives one registered write port.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned SRC_COUNT  = 4,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [SRC_COUNT-1:0]                  src_valid_i,
   output logic [SRC_COUNT-1:0]                  src_ready_o,
   input  logic [SRC_COUNT-1:0][ADDR_DEPTH-1:0]  src_waddr_i,
   input  logic [SRC_COUNT-1:0][DATA_WIDTH-1:0]  src_wdata_i,
   output logic                                  we_o,
   output logic [ADDR_DEPTH-1:0]                 waddr_o,
   output logic [DATA_WIDTH-1:0]                 wdata_o,
   output logic                                  busy_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SRC_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

   logic [ADDR_DEPTH-1:0] mem_addr [SRC_COUNT][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [SRC_COUNT][FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr   [SRC_COUNT];
   logic [PTR_W-1:0]      rd_ptr   [SRC_COUNT];
   logic [CNT_W-1:0]      count    [SRC_COUNT];

   logic [SRC_COUNT-1:0]  cand;
   logic [SRC_COUNT-1:0]  push;
   logic [SRC_COUNT-1:0]  pop;
   logic                  grant_valid;
   logic [SRC_W-1:0]      winner;
   logic [SRC_W-1:0]      rr_ptr;
   logic [SRC_W-1:0]      rr_next;

   // Ready comes from the registered count only, so a full FIFO never passes through.
   always_comb begin
      src_ready_o = '0;
      cand        = '0;
      push        = '0;
      for (int unsigned s = 0; s < SRC_COUNT; s++) begin
         src_ready_o[s] = (count[s] != CNT_W'(FIFO_DEPTH)) && rst_n;
         cand[s]        = (count[s] != '0);
         push[s]        = src_valid_i[s] && src_ready_o[s];
      end
   end

   // Round-robin search upward from rr_ptr, wrapping modulo SRC_COUNT.
   always_comb begin
      grant_valid = 1'b0;
      winner      = '0;
      for (int unsigned i = 0; i < SRC_COUNT; i++) begin
         if (!grant_valid && cand[SRC_W'((32'(rr_ptr) + i) % SRC_COUNT)]) begin
            grant_valid = 1'b1;
            winner      = SRC_W'((32'(rr_ptr) + i) % SRC_COUNT);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int unsigned s = 0; s < SRC_COUNT; s++) begin
         pop[s] = grant_valid && (winner == SRC_W'(s));
      end
   end

   always_comb begin
      rr_next = rr_ptr;
      if (grant_valid) begin
         rr_next = (32'(winner) == SRC_COUNT - 1) ? '0 : winner + SRC_W'(1);
      end
   end

   // FIFO storage carries no reset; only pointers and counts define occupancy.
   always_ff @(posedge clk) begin
      for (int unsigned s = 0; s < SRC_COUNT; s++) begin
         if (push[s]) begin
            mem_addr[s][wr_ptr[s]] <= src_waddr_i[s];
            mem_data[s][wr_ptr[s]] <= src_wdata_i[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SRC_COUNT; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
            count[s]  <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < SRC_COUNT; s++) begin
            if (push[s]) begin
               wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
            end
            if (pop[s]) begin
               rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
            end
            if (push[s] && !pop[s]) begin
               count[s] <= count[s] + CNT_W'(1);
            end else if (!push[s] && pop[s]) begin
               count[s] <= count[s] - CNT_W'(1);
            end
         end
      end
   end

   // Registered write port; address/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr  <= '0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         rr_ptr <= rr_next;
         we_o   <= grant_valid;
         if (grant_valid) begin
            waddr_o <= mem_addr[winner][rd_ptr[winner]];
            wdata_o <= mem_data[winner][rd_ptr[winner]];
         end
      end
   end

   assign busy_o = we_o || (|cand);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus
// scoreboarded sequences for fairness, backpressure and mid-stream reset.
module tb_regfile_wb_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;
   localparam int unsigned NS = 4;
   localparam int unsigned NV = 16;

   logic                   clk;
   logic                   rst_n;
   logic [NS-1:0]          src_valid;
   logic [NS-1:0]          src_ready;
   logic [NS-1:0][AW-1:0]  src_waddr;
   logic [NS-1:0][DW-1:0]  src_wdata;
   logic                   we;
   logic [AW-1:0]          waddr;
   logic [DW-1:0]          wdata;
   logic                   busy;

   regfile_wb_arbiter #(
      .DATA_WIDTH (DW),
      .DEPTH      (64),
      .SRC_COUNT  (NS),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_valid_i (src_valid),
      .src_ready_o (src_ready),
      .src_waddr_i (src_waddr),
      .src_wdata_i (src_wdata),
      .we_o        (we),
      .waddr_o     (waddr),
      .wdata_o     (wdata),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NS-1:0]          valid;
      logic [NS-1:0][AW-1:0]  addr;
      logic [NS-1:0][DW-1:0]  data;
      logic                   exp_we;
      logic [AW-1:0]          exp_waddr;
      logic [DW-1:0]          exp_wdata;
      logic                   exp_busy;
      logic [NS-1:0]          exp_ready;
   } vec_t;

   vec_t        tbl [NV];
   int          checks;
   int          errors;
   logic [37:0] q [NS][$];
   int          seq [NS];
   int          accepted;
   int          written;
   int          last_src;
   bit          fair_on;
   bit          saw_stall;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Source s gets address a+s and data d*(s+1).
   function automatic vec_t mk(input logic [NS-1:0] v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic e_we,
                               input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd,
                               input logic e_busy, input logic [NS-1:0] e_rdy);
      vec_t r;
      r.valid = v;
      for (int s = 0; s < NS; s++) begin
         r.addr[s] = a + AW'(s);
         r.data[s] = d * DW'(s + 1);
      end
      r.exp_we    = e_we;
      r.exp_waddr = e_wa;
      r.exp_wdata = e_wd;
      r.exp_busy  = e_busy;
      r.exp_ready = e_rdy;
      return r;
   endfunction

   // Drive one cycle, check ready against the scoreboard occupancy, then check the write.
   task automatic sb_step(input logic [NS-1:0] v);
      int src;
      logic [37:0] e;
      for (int s = 0; s < NS; s++) begin
         src_valid[s] = v[s];
         src_waddr[s] = {2'(s), 4'(seq[s])};
         src_wdata[s] = {4'(s), 28'(seq[s])};
      end
      #1;
      for (int s = 0; s < NS; s++) begin
         chk("ready_vs_occupancy", 64'(src_ready[s]), 64'(q[s].size() != 2));
         if (v[s] && !src_ready[s]) saw_stall = 1'b1;
         if (v[s] && src_ready[s]) begin
            q[s].push_back({src_waddr[s], src_wdata[s]});
            accepted++;
            seq[s]++;
         end
      end
      @(posedge clk);
      #1;
      if (we === 1'b1) begin
         src = int'(wdata[31:28]);
         written++;
         if (src >= NS || q[src].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_write act=%0h/%0h exp=none", waddr, wdata);
         end else begin
            e = q[src].pop_front();
            chk("sb_pair", 64'({waddr, wdata}), 64'(e));
            if (fair_on && last_src >= 0) chk("rr_alternate", 64'(src != last_src), 64'd1);
            last_src = src;
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      accepted  = 0;
      written   = 0;
      last_src  = -1;
      fair_on   = 1'b0;
      saw_stall = 1'b0;
      for (int s = 0; s < NS; s++) seq[s] = 0;
      rst_n     = 1'b0;
      src_valid = '0;
      src_waddr = '0;
      src_wdata = '0;

      // test 2: four simultaneous, rr from 0
      tbl[0]  = mk(4'b1111, 6'd1, 32'h11, 1'b0, 6'd0, 32'h0,  1'b1, 4'b1111);
      tbl[1]  = mk(4'b0000, 6'd0, 32'h0,  1'b1, 6'd1, 32'h11, 1'b1, 4'b1111);
      tbl[2]  = mk(4'b0000, 6'd0, 32'h0,  1'b1, 6'd2, 32'h22, 1'b1, 4'b1111);
      tbl[3]  = mk(4'b0000, 6'd0, 32'h0,  1'b1, 6'd3, 32'h33, 1'b1, 4'b1111);
      tbl[4]  = mk(4'b0000, 6'd0, 32'h0,  1'b1, 6'd4, 32'h44, 1'b1, 4'b1111);
      tbl[5]  = mk(4'b0000, 6'd0, 32'h0,  1'b0, 6'd4, 32'h44, 1'b0, 4'b1111);
      // test 1: single write, 2-edge latency
      tbl[6]  = mk(4'b0001, 6'd5, 32'hDEADBEEF, 1'b0, 6'd4, 32'h44,       1'b1, 4'b1111);
      tbl[7]  = mk(4'b0000, 6'd0, 32'h0,        1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 4'b1111);
      tbl[8]  = mk(4'b0000, 6'd0, 32'h0,        1'b0, 6'd5, 32'hDEADBEEF, 1'b0, 4'b1111);
      // test 5: src2 full while granted, offered entry dropped
      tbl[9]  = mk(4'b0101, 6'd20, 32'h100, 1'b0, 6'd5,  32'hDEADBEEF, 1'b1, 4'b1111);
      tbl[10] = mk(4'b0101, 6'd24, 32'h101, 1'b1, 6'd22, 32'h300,      1'b1, 4'b1110);
      tbl[11] = mk(4'b0101, 6'd28, 32'h102, 1'b1, 6'd20, 32'h100,      1'b1, 4'b1011);
      tbl[12] = mk(4'b0100, 6'd32, 32'h103, 1'b1, 6'd26, 32'h303,      1'b1, 4'b1111);
      tbl[13] = mk(4'b0000, 6'd0,  32'h0,   1'b1, 6'd24, 32'h101,      1'b1, 4'b1111);
      tbl[14] = mk(4'b0000, 6'd0,  32'h0,   1'b1, 6'd30, 32'h306,      1'b1, 4'b1111);
      tbl[15] = mk(4'b0000, 6'd0,  32'h0,   1'b0, 6'd30, 32'h306,      1'b0, 4'b1111);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_low", 64'(src_ready), 64'h0);
      chk("rst_we",        64'(we),        64'h0);
      chk("rst_waddr",     64'(waddr),     64'h0);
      chk("rst_wdata",     64'(wdata),     64'h0);
      chk("rst_busy",      64'(busy),      64'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 64'(src_ready), 64'hF);

      for (int i = 0; i < NV; i++) begin
         src_valid = tbl[i].valid;
         src_waddr = tbl[i].addr;
         src_wdata = tbl[i].data;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", i),    64'(we),        64'(tbl[i].exp_we));
         chk($sformatf("v%0d_waddr", i), 64'(waddr),     64'(tbl[i].exp_waddr));
         chk($sformatf("v%0d_wdata", i), 64'(wdata),     64'(tbl[i].exp_wdata));
         chk($sformatf("v%0d_busy", i),  64'(busy),      64'(tbl[i].exp_busy));
         chk($sformatf("v%0d_ready", i), 64'(src_ready), 64'(tbl[i].exp_ready));
      end

      // test 3: src0 and src3 saturated must alternate
      fair_on  = 1'b1;
      last_src = -1;
      repeat (16) sb_step(4'b1001);
      fair_on = 1'b0;
      repeat (6) sb_step(4'b0000);

      // test 4: all sources saturated, FIFOs fill and stall
      fair_on  = 1'b1;
      last_src = -1;
      repeat (20) sb_step(4'b1111);
      fair_on = 1'b0;
      repeat (10) sb_step(4'b0000);
      chk("bp_stall_seen", 64'(saw_stall), 64'd1);
      chk("bp_acc_eq_wr",  64'(accepted),  64'(written));
      chk("bp_q_empty",    64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);

      // test 6: reset with entries buffered and a write in the output register
      sb_step(4'b0111);
      sb_step(4'b0111);
      chk("r6_we_before", 64'(we), 64'd1);
      rst_n     = 1'b0;
      src_valid = '0;
      #1;
      chk("r6_ready_low", 64'(src_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("r6_we",    64'(we),    64'h0);
      chk("r6_waddr", 64'(waddr), 64'h0);
      chk("r6_wdata", 64'(wdata), 64'h0);
      chk("r6_busy",  64'(busy),  64'h0);
      rst_n = 1'b1;
      for (int s = 0; s < NS; s++) q[s].delete();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("r6_no_stale_write", 64'({we, busy}), 64'h0);
      end
      src_valid    = 4'b0010;
      src_waddr[1] = 6'd9;
      src_wdata[1] = 32'h99;
      @(posedge clk);
      #1;
      src_valid = '0;
      chk("r6_new_lat1_we", 64'(we),   64'h0);
      chk("r6_new_busy",    64'(busy), 64'h1);
      @(posedge clk);
      #1;
      chk("r6_new_we",    64'(we),    64'h1);
      chk("r6_new_waddr", 64'(waddr), 64'd9);
      chk("r6_new_wdata", 64'(wdata), 64'h99);
      @(posedge clk);
      #1;
      chk("r6_new_done", 64'({we, busy}), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
